// File: rtl/sc_level_sequencer_pkg.sv
// Shared level/state constants for the level sequencer and the
// vehicle level machines that consume NVL and the CN strobe.
package sc_level_sequencer_pkg;

    localparam int NVL_W   = 2;
    localparam int LIVES_W = 2;
    localparam int WINS_W  = 4;
    localparam int GAP_W   = 8;

    localparam logic [NVL_W-1:0] NVL_MIN = 2'd0;
    localparam logic [NVL_W-1:0] NVL_MAX = 2'd3;

    typedef enum logic [3:0] {
        SC_ST_IDLE       = 4'd0,
        SC_ST_ARM        = 4'd1,
        SC_ST_LOAD       = 4'd2,
        SC_ST_RUN        = 4'd3,
        SC_ST_RELEASE    = 4'd4,
        SC_ST_GAP        = 4'd5,
        SC_ST_FINISH_REL = 4'd6,
        SC_ST_GAMEOVER   = 4'd7,
        SC_ST_VICTORY    = 4'd8
    } sc_levelseq_state_e;

    // CN is raised for exactly one cycle in each of these states
    function automatic logic sc_is_strobe_state(
        input sc_levelseq_state_e s
    );
        return (s == SC_ST_LOAD) ||
               (s == SC_ST_RELEASE) ||
               (s == SC_ST_FINISH_REL);
    endfunction

endpackage

// File: rtl/sc_gap_timer.sv
// Down-counter that times the CN-low gap before each level load.
// done is decoded from the register so it carries no input path.
module sc_gap_timer
    import sc_level_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic SC_GAPTIMER_CLOCK_50,
    input  logic SC_GAPTIMER_RESET,
    input  logic SC_GAPTIMER_LOAD,
    input  logic SC_GAPTIMER_EN,
    output logic SC_GAPTIMER_DONE
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    logic [GAP_W-1:0] count_q;

    always_ff @(posedge SC_GAPTIMER_CLOCK_50) begin
        if (SC_GAPTIMER_RESET) begin
            count_q <= '0;
        end else if (SC_GAPTIMER_LOAD) begin
            count_q <= GAP_LOAD;
        end else if (SC_GAPTIMER_EN && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Last counting cycle: the count reaches 0 on this edge
    assign SC_GAPTIMER_DONE = (count_q == GAP_W'(1));

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger level sequencer: lives, wins per level, level strobes
// and the end-of-game states driven to the vehicle level machines.
module sc_level_sequencer
    import sc_level_sequencer_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int WINS_PER_LEVEL = 2,
    parameter int GAP_CYCLES     = 4
) (
    input  logic               SC_LEVELSEQ_CLOCK_50,
    input  logic               SC_LEVELSEQ_RESET,
    input  logic               SC_LEVELSEQ_START_IN,
    input  logic               SC_LEVELSEQ_WIN_IN,
    input  logic               SC_LEVELSEQ_LOSE_IN,
    output logic [NVL_W-1:0]   SC_LEVELSEQ_NVL_OUT,
    output logic               SC_LEVELSEQ_CN_OUT,
    output logic [LIVES_W-1:0] SC_LEVELSEQ_LIVES_OUT,
    output logic               SC_LEVELSEQ_RUN_OUT,
    output logic               SC_LEVELSEQ_GAMEOVER_OUT,
    output logic               SC_LEVELSEQ_VICTORY_OUT
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [WINS_W-1:0]  WINS_LAST  =
        WINS_W'(WINS_PER_LEVEL - 1);

    sc_levelseq_state_e state_q, state_nxt;

    logic [NVL_W-1:0]   nvl_q, nvl_nxt;
    logic [LIVES_W-1:0] lives_q, lives_nxt;
    logic [WINS_W-1:0]  wins_q, wins_nxt;

    logic gap_load;
    logic gap_en;
    logic gap_done;

    sc_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .SC_GAPTIMER_CLOCK_50(SC_LEVELSEQ_CLOCK_50),
        .SC_GAPTIMER_RESET   (SC_LEVELSEQ_RESET),
        .SC_GAPTIMER_LOAD    (gap_load),
        .SC_GAPTIMER_EN      (gap_en),
        .SC_GAPTIMER_DONE    (gap_done)
    );

    always_ff @(posedge SC_LEVELSEQ_CLOCK_50) begin
        if (SC_LEVELSEQ_RESET) begin
            state_q <= SC_ST_IDLE;
            nvl_q   <= NVL_MIN;
            lives_q <= LIVES_LOAD;
            wins_q  <= '0;
        end else begin
            state_q <= state_nxt;
            nvl_q   <= nvl_nxt;
            lives_q <= lives_nxt;
            wins_q  <= wins_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        nvl_nxt   = nvl_q;
        lives_nxt = lives_q;
        wins_nxt  = wins_q;
        gap_load  = 1'b0;
        gap_en    = 1'b0;

        unique case (state_q)
            SC_ST_IDLE: begin
                if (SC_LEVELSEQ_START_IN) begin
                    gap_load  = 1'b1;
                    state_nxt = SC_ST_ARM;
                end
            end

            SC_ST_ARM,
            SC_ST_GAP: begin
                gap_en = 1'b1;
                if (gap_done) begin
                    state_nxt = SC_ST_LOAD;
                end
            end

            SC_ST_LOAD: begin
                state_nxt = SC_ST_RUN;
            end

            SC_ST_RUN: begin
                // A loss swallows any win arriving in the same cycle
                if (SC_LEVELSEQ_LOSE_IN) begin
                    if (lives_q != '0) begin
                        lives_nxt = lives_q - 1'b1;
                    end
                    if (lives_q <= LIVES_W'(1)) begin
                        state_nxt = SC_ST_FINISH_REL;
                    end
                end else if (SC_LEVELSEQ_WIN_IN) begin
                    if (wins_q >= WINS_LAST) begin
                        wins_nxt = '0;
                        if (nvl_q == NVL_MAX) begin
                            state_nxt = SC_ST_FINISH_REL;
                        end else begin
                            state_nxt = SC_ST_RELEASE;
                        end
                    end else begin
                        wins_nxt = wins_q + 1'b1;
                    end
                end
            end

            SC_ST_RELEASE: begin
                if (nvl_q != NVL_MAX) begin
                    nvl_nxt = nvl_q + 1'b1;
                end
                gap_load  = 1'b1;
                state_nxt = SC_ST_GAP;
            end

            SC_ST_FINISH_REL: begin
                // Lives only reach zero on the losing path
                if (lives_q == '0) begin
                    state_nxt = SC_ST_GAMEOVER;
                end else begin
                    state_nxt = SC_ST_VICTORY;
                end
            end

            SC_ST_GAMEOVER,
            SC_ST_VICTORY: begin
                if (SC_LEVELSEQ_START_IN) begin
                    nvl_nxt   = NVL_MIN;
                    lives_nxt = LIVES_LOAD;
                    wins_nxt  = '0;
                    gap_load  = 1'b1;
                    state_nxt = SC_ST_ARM;
                end
            end

            default: begin
                state_nxt = SC_ST_IDLE;
            end
        endcase
    end

    assign SC_LEVELSEQ_NVL_OUT      = nvl_q;
    assign SC_LEVELSEQ_LIVES_OUT    = lives_q;
    assign SC_LEVELSEQ_CN_OUT       = sc_is_strobe_state(state_q);
    assign SC_LEVELSEQ_RUN_OUT      = (state_q == SC_ST_RUN);
    assign SC_LEVELSEQ_GAMEOVER_OUT = (state_q == SC_ST_GAMEOVER);
    assign SC_LEVELSEQ_VICTORY_OUT  = (state_q == SC_ST_VICTORY);

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Directed plus random checks of sc_level_sequencer against a
// timeline model of the game (scripted gaps, free play, end states).
module tb_sc_level_sequencer;

    localparam int G = 4;
    localparam int W = 2;
    localparam int L = 3;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    localparam int M_WON  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       win = 1'b0;
    logic       lose = 1'b0;
    logic [1:0] nvl;
    logic       cn;
    logic [1:0] lives;
    logic       run;
    logic       over;
    logic       won;

    always #10 clk = ~clk;

    sc_level_sequencer #(
        .LIVES_INIT    (L),
        .WINS_PER_LEVEL(W),
        .GAP_CYCLES    (G)
    ) dut (
        .SC_LEVELSEQ_CLOCK_50    (clk),
        .SC_LEVELSEQ_RESET       (rst),
        .SC_LEVELSEQ_START_IN    (start),
        .SC_LEVELSEQ_WIN_IN      (win),
        .SC_LEVELSEQ_LOSE_IN     (lose),
        .SC_LEVELSEQ_NVL_OUT     (nvl),
        .SC_LEVELSEQ_CN_OUT      (cn),
        .SC_LEVELSEQ_LIVES_OUT   (lives),
        .SC_LEVELSEQ_RUN_OUT     (run),
        .SC_LEVELSEQ_GAMEOVER_OUT(over),
        .SC_LEVELSEQ_VICTORY_OUT (won)
    );

    typedef struct packed {
        logic       cn;
        logic [1:0] nvl;
        logic [1:0] lives;
        logic       run;
        logic       over;
        logic       won;
    } obs_t;

    obs_t q[$];
    obs_t exp_o;

    int m_lvl;
    int m_lives;
    int m_wins;
    int m_mode;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, obs, expv);
        end
    endtask

    function automatic obs_t mk(input logic c, input int lv,
                                input int li, input logic r,
                                input logic o, input logic w);
        obs_t t;
        t.cn    = c;
        t.nvl   = 2'(lv);
        t.lives = 2'(li);
        t.run   = r;
        t.over  = o;
        t.won   = w;
        return t;
    endfunction

    // Gap of G quiet cycles, one load strobe, then the first
    // playing cycle (inputs are not yet acted on at that edge).
    task automatic schedule_level();
        for (int i = 0; i < G; i++)
            q.push_back(mk(1'b0, m_lvl, m_lives, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, m_lvl, m_lives, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, m_lvl, m_lives, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic new_game();
        m_lvl   = 0;
        m_lives = L;
        m_wins  = 0;
        m_mode  = M_PLAY;
        schedule_level();
        exp_o = q.pop_front();
    endtask

    task automatic model_step();
        if (rst) begin
            q.delete();
            m_mode  = M_IDLE;
            m_lvl   = 0;
            m_lives = L;
            m_wins  = 0;
            exp_o   = mk(1'b0, 0, L, 1'b0, 1'b0, 1'b0);
        end else if (q.size() > 0) begin
            exp_o = q.pop_front();
        end else if (m_mode == M_PLAY) begin
            exp_o = mk(1'b0, m_lvl, m_lives, 1'b1, 1'b0, 1'b0);
            if (lose) begin
                m_lives--;
                exp_o.lives = 2'(m_lives);
                if (m_lives == 0) begin
                    m_mode = M_OVER;
                    exp_o  = mk(1'b1, m_lvl, 0, 1'b0, 1'b0, 1'b0);
                    q.push_back(mk(1'b0, m_lvl, 0, 1'b0, 1'b1, 1'b0));
                end
            end else if (win) begin
                m_wins++;
                if (m_wins == W) begin
                    m_wins = 0;
                    exp_o  = mk(1'b1, m_lvl, m_lives,
                                1'b0, 1'b0, 1'b0);
                    if (m_lvl == 3) begin
                        m_mode = M_WON;
                        q.push_back(mk(1'b0, m_lvl, m_lives,
                                       1'b0, 1'b0, 1'b1));
                    end else begin
                        m_lvl++;
                        schedule_level();
                    end
                end
            end
        end else if (start) begin
            if (m_mode == M_IDLE) begin
                m_mode = M_PLAY;
                schedule_level();
                exp_o = q.pop_front();
            end else begin
                new_game();
            end
        end else begin
            exp_o = mk(1'b0, m_lvl, m_lives, 1'b0,
                       m_mode == M_OVER, m_mode == M_WON);
        end
    endtask

    task automatic cyc(input logic s, input logic w,
                       input logic l, input logic r);
        @(negedge clk);
        start = s;
        win   = w;
        lose  = l;
        rst   = r;
        @(posedge clk);
        model_step();
        #1;
        check("cn",    cn,    exp_o.cn);
        check("nvl",   nvl,   exp_o.nvl);
        check("lives", lives, exp_o.lives);
        check("run",   run,   exp_o.run);
        check("over",  over,  exp_o.over);
        check("won",   won,   exp_o.won);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_mode  = M_IDLE;
        m_lvl   = 0;
        m_lives = L;
        m_wins  = 0;

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Start, gap, load, run
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Two wins: release, gap at level 1, load, run
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);

        // Simultaneous win/lose: the win must not count
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);

        // Remaining lives lost, game over, stray pulses ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Restart and climb to victory
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            idle(7);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Reset in the middle of a gap
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 7) == 0,
                $urandom_range(0, 15) < 5,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 599) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
